ajc_mmio_port_ctrl: RTL and testbench
=====================================

// Module: ajc_mmio_port_ctrl
// PURPOSE
//  Parametrised memory-mapped I/O controller replacing fixed IPDR/OPDR wiring of the 8-bit RISC.
//  N_IN pushbutton/switch input channels (sync + debounce + press-latched data, READY/overrun flags,
//  interrupt) and N_OUT LED output registers, all accessed by the CPU over a simple addressed bus.
//  Sits between the core's MAR/RW bus and board PB/SW/LED pins.
// PARAMETERS
//  DATA_W      8    bus data width; LED width per output channel
//  ADDR_W      8    bus address width
//  BASE_ADDR   8'hF0 first address of the register window
//  N_IN        2    input channels (1..DATA_W/2)
//  IN_W        4    switch bits per input channel (<= DATA_W)
//  N_OUT       2    output (LED) channels
//  DEB_CYCLES  16   consecutive stable samples required to accept a PB level change (>=2)
// PORTS
//  Clock   in   1               system clock, rising edge
//  Reset   in   1               asynchronous, active-low reset
//  PB      in   N_IN            raw pushbuttons, active-high, asynchronous
//  SW      in   N_IN*IN_W       raw switches, channel i at [i*IN_W +: IN_W]
//  BUS_EN  in   1               bus cycle strobe, one cycle per access
//  BUS_RW  in   1               1 = read, 0 = write
//  BUS_A   in   ADDR_W          byte address
//  BUS_WD  in   DATA_W          write data
//  BUS_RD  out  DATA_W          registered read data
//  BUS_RV  out  1               read-valid pulse
//  LEDs    out  N_OUT*DATA_W    output registers, channel j at [j*DATA_W +: DATA_W]
//  IRQ     out  1               |(READY & IE), registered
// BEHAVIOUR
//  Reset (Reset=0, async): every register, flag, counter, BUS_RD, BUS_RV, LEDs, IRQ -> 0.
//  Register map, offset = BUS_A - BASE_ADDR:
//   0 STATUS  RO[N_IN-1:0]=READY, W1C[2N_IN-1:N_IN]=OVR, other bits read 0
//   1 CTRL    RW[N_IN-1:0]=IE, other bits read 0 / ignore writes
//   2+i       IPDR[i] RO, latched SW of channel i zero-extended to DATA_W
//   2+N_IN+j  OPDR[j] RW, drives LEDs channel j
//   outside window / other offsets: reads return 0 (BUS_RV still pulses), writes ignored.
//  Inputs: PB and SW each pass a 2-flop synchroniser. Per-channel debounce: counter resets to 0
//   whenever synced PB equals debounced state; else increments; on reaching DEB_CYCLES-1 the
//   debounced state toggles and counter clears. Counter saturates, never wraps.
//  Press event = debounced 0->1 edge (one-cycle pulse); release ignored.
//   - READY[i]=0: IPDR[i] <= synced SW channel i, READY[i] <= 1.
//   - READY[i]=1 and no read of IPDR[i] this cycle: IPDR unchanged, OVR[i] <= 1.
//   - same-cycle read of IPDR[i] and press: read returns OLD data; IPDR takes new data,
//     READY stays 1, OVR unchanged.
//  Read of IPDR[i] clears READY[i] on the access edge (unless same-cycle press, above).
//  STATUS write: OVR[k] cleared where BUS_WD bit N_IN+k = 1; same-cycle new overrun wins (stays 1).
//  Reads: BUS_EN&BUS_RW sampled at edge n -> BUS_RD valid and BUS_RV=1 during cycle n+1;
//   BUS_RD holds value until next read; BUS_RV is a one-cycle pulse.
//  Writes: BUS_EN&~BUS_RW at edge n -> register/LEDs updated after edge n; no BUS_RV.
//  BUS_EN back-to-back every cycle supported; no wait states.
//  IRQ registered: reflects READY/IE one cycle after they change.
//  Latency pin->READY: 2 (sync) + DEB_CYCLES (+1 edge) cycles after PB goes stable high.
//  Reset asserted mid-debounce or mid-access: all state discarded, no spurious press after release.
// TESTING (bench uses defaults except DEB_CYCLES=4, BASE_ADDR=8'hF0)
//  1 Reset -> LEDs=16'h0000, BUS_RD=0, BUS_RV=0, IRQ=0; read F0 returns 8'h00.
//  2 SW[3:0]=4'hA, PB[0] high 10 clk -> READY[0]=1; read F2 -> BUS_RD=8'h0A, BUS_RV 1 clk later;
//    read F0 then returns 8'h00.
//  3 PB[0] glitch high 2 clk then low -> no press; READY stays 0, F0 reads 8'h00.
//  4 Two presses SW=4'h3 then 4'h5 without read -> F2=8'h03, F0=8'h05 (READY0,OVR0);
//    write F0<=8'h04 -> F0=8'h01.
//  5 Write CTRL F1<=8'h02, press ch1 -> IRQ=1; read F3 -> IRQ=0 within 2 clk.
//  6 Write F4<=8'h5A, F5<=8'hC3 -> LEDs=16'hC35A next clk; write FF ignored; read FF -> 8'h00, BUS_RV=1.

Source files
------------

// File: rtl/ajc_mmio_port_ctrl.sv
// Memory-mapped I/O port controller: debounced pushbutton-latched switch inputs with
// READY/overrun flags and interrupt, plus LED output registers on a simple addressed bus.
module ajc_mmio_port_ctrl #(
  parameter int                DATA_W     = 8,
  parameter int                ADDR_W     = 8,
  parameter logic [ADDR_W-1:0] BASE_ADDR  = 'hF0,
  parameter int                N_IN       = 2,
  parameter int                IN_W       = 4,
  parameter int                N_OUT      = 2,
  parameter int                DEB_CYCLES = 16
) (
  input  logic                    Clock,
  input  logic                    Reset,
  input  logic [N_IN-1:0]         PB,
  input  logic [N_IN*IN_W-1:0]    SW,
  input  logic                    BUS_EN,
  input  logic                    BUS_RW,
  input  logic [ADDR_W-1:0]       BUS_A,
  input  logic [DATA_W-1:0]       BUS_WD,
  output logic [DATA_W-1:0]       BUS_RD,
  output logic                    BUS_RV,
  output logic [N_OUT*DATA_W-1:0] LEDs,
  output logic                    IRQ
);

  localparam int                N_REG   = 2 + N_IN + N_OUT;
  localparam int                CNT_W   = $clog2(DEB_CYCLES);
  localparam logic [CNT_W-1:0]  CNT_MAX = CNT_W'(DEB_CYCLES - 1);

  logic [N_IN-1:0]      pb_s1_q, pb_s2_q, deb_q, deb_d, press_q, press_d;
  logic [N_IN-1:0]      ready_q, ready_d, ovr_q, ovr_d, ie_q, ie_d;
  logic [N_IN*IN_W-1:0] sw_s1_q, sw_s2_q;
  logic [CNT_W-1:0]     cnt_q [N_IN];
  logic [CNT_W-1:0]     cnt_d [N_IN];
  logic [IN_W-1:0]      ipdr_q [N_IN];
  logic [IN_W-1:0]      ipdr_d [N_IN];
  logic [DATA_W-1:0]    opdr_q [N_OUT];
  logic [DATA_W-1:0]    opdr_d [N_OUT];
  logic [DATA_W-1:0]    bus_rd_q, bus_rd_d, rdata;
  logic                 bus_rv_q, bus_rv_d, irq_q, irq_d;

  logic [ADDR_W-1:0]    off;
  logic                 in_win, rd, wr;
  logic [N_IN-1:0]      rd_ipdr;

  // Offset wraps below the base, so the window needs both bounds.
  assign off    = BUS_A - BASE_ADDR;
  assign in_win = (BUS_A >= BASE_ADDR) && (off < ADDR_W'(N_REG));
  assign rd     = BUS_EN & BUS_RW;
  assign wr     = BUS_EN & ~BUS_RW;

  always_comb begin
    rdata   = '0;
    rd_ipdr = '0;
    if (in_win) begin
      if (off == ADDR_W'(0)) begin
        rdata[N_IN-1:0]      = ready_q;
        rdata[2*N_IN-1:N_IN] = ovr_q;
      end
      if (off == ADDR_W'(1)) rdata[N_IN-1:0] = ie_q;
      for (int i = 0; i < N_IN; i++) begin
        if (off == ADDR_W'(2 + i)) begin
          rdata[IN_W-1:0] = ipdr_q[i];
          rd_ipdr[i]      = rd;
        end
      end
      for (int j = 0; j < N_OUT; j++)
        if (off == ADDR_W'(2 + N_IN + j)) rdata = opdr_q[j];
    end
  end

  always_comb begin
    deb_d   = deb_q;
    cnt_d   = cnt_q;
    press_d = '0;
    for (int i = 0; i < N_IN; i++) begin
      if (pb_s2_q[i] == deb_q[i]) begin
        cnt_d[i] = '0;
      end else if (cnt_q[i] == CNT_MAX) begin
        deb_d[i]   = ~deb_q[i];
        cnt_d[i]   = '0;
        press_d[i] = ~deb_q[i];
      end else begin
        cnt_d[i] = cnt_q[i] + 1'b1;
      end
    end
  end

  always_comb begin
    ready_d = ready_q;
    ovr_d   = ovr_q;
    ie_d    = ie_q;
    ipdr_d  = ipdr_q;
    opdr_d  = opdr_q;
    if (wr && in_win && off == ADDR_W'(0)) ovr_d = ovr_q & ~BUS_WD[2*N_IN-1:N_IN];
    if (wr && in_win && off == ADDR_W'(1)) ie_d = BUS_WD[N_IN-1:0];
    for (int j = 0; j < N_OUT; j++)
      if (wr && in_win && off == ADDR_W'(2 + N_IN + j)) opdr_d[j] = BUS_WD;
    // Overrun is set after the W1C clear so a same-cycle new overrun wins.
    for (int i = 0; i < N_IN; i++) begin
      if (press_q[i]) begin
        if (!ready_q[i]) begin
          ipdr_d[i]  = sw_s2_q[i*IN_W +: IN_W];
          ready_d[i] = 1'b1;
        end else if (rd_ipdr[i]) begin
          ipdr_d[i]  = sw_s2_q[i*IN_W +: IN_W];
        end else begin
          ovr_d[i]   = 1'b1;
        end
      end else if (rd_ipdr[i]) begin
        ready_d[i] = 1'b0;
      end
    end
    bus_rd_d = rd ? rdata : bus_rd_q;
    bus_rv_d = rd;
    irq_d    = |(ready_q & ie_q);
  end

  always_ff @(posedge Clock or negedge Reset) begin
    if (!Reset) begin
      pb_s1_q  <= '0;
      pb_s2_q  <= '0;
      sw_s1_q  <= '0;
      sw_s2_q  <= '0;
      deb_q    <= '0;
      press_q  <= '0;
      ready_q  <= '0;
      ovr_q    <= '0;
      ie_q     <= '0;
      bus_rd_q <= '0;
      bus_rv_q <= 1'b0;
      irq_q    <= 1'b0;
      for (int i = 0; i < N_IN; i++) begin
        cnt_q[i]  <= '0;
        ipdr_q[i] <= '0;
      end
      for (int j = 0; j < N_OUT; j++) opdr_q[j] <= '0;
    end else begin
      pb_s1_q  <= PB;
      pb_s2_q  <= pb_s1_q;
      sw_s1_q  <= SW;
      sw_s2_q  <= sw_s1_q;
      deb_q    <= deb_d;
      press_q  <= press_d;
      ready_q  <= ready_d;
      ovr_q    <= ovr_d;
      ie_q     <= ie_d;
      bus_rd_q <= bus_rd_d;
      bus_rv_q <= bus_rv_d;
      irq_q    <= irq_d;
      cnt_q    <= cnt_d;
      ipdr_q   <= ipdr_d;
      opdr_q   <= opdr_d;
    end
  end

  for (genvar j = 0; j < N_OUT; j++) begin : g_led
    assign LEDs[j*DATA_W +: DATA_W] = opdr_q[j];
  end

  assign BUS_RD = bus_rd_q;
  assign BUS_RV = bus_rv_q;
  assign IRQ    = irq_q;

endmodule

// File: tb/tb_ajc_mmio_port_ctrl.sv
// Directed bench for ajc_mmio_port_ctrl with DEB_CYCLES=4 and the register window at 8'hF0.
module tb_ajc_mmio_port_ctrl;

  logic        Clock = 1'b0;
  logic        Reset;
  logic [1:0]  PB;
  logic [7:0]  SW;
  logic        BUS_EN, BUS_RW;
  logic [7:0]  BUS_A, BUS_WD;
  logic [7:0]  BUS_RD;
  logic        BUS_RV;
  logic [15:0] LEDs;
  logic        IRQ;

  int checks   = 0;
  int failures = 0;

  ajc_mmio_port_ctrl #(
    .DATA_W(8), .ADDR_W(8), .BASE_ADDR(8'hF0), .N_IN(2), .IN_W(4), .N_OUT(2), .DEB_CYCLES(4)
  ) dut (
    .Clock(Clock), .Reset(Reset), .PB(PB), .SW(SW),
    .BUS_EN(BUS_EN), .BUS_RW(BUS_RW), .BUS_A(BUS_A), .BUS_WD(BUS_WD),
    .BUS_RD(BUS_RD), .BUS_RV(BUS_RV), .LEDs(LEDs), .IRQ(IRQ)
  );

  always #5 Clock = ~Clock;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge Clock);
    #1;
  endtask

  task automatic bus_write(input logic [7:0] a, input logic [7:0] d);
    BUS_EN = 1'b1; BUS_RW = 1'b0; BUS_A = a; BUS_WD = d;
    tick(1);
    BUS_EN = 1'b0;
  endtask

  task automatic bus_read(input logic [7:0] a, input string tag, input logic [7:0] exp);
    BUS_EN = 1'b1; BUS_RW = 1'b1; BUS_A = a;
    tick(1);
    BUS_EN = 1'b0;
    chk({tag, "_rv"}, {31'd0, BUS_RV}, 32'd1);
    chk(tag, {24'd0, BUS_RD}, {24'd0, exp});
  endtask

  task automatic press(input int ch, input logic [3:0] sw_val);
    SW[ch*4 +: 4] = sw_val;
    tick(3);
    PB[ch] = 1'b1;
    tick(10);
    PB[ch] = 1'b0;
    tick(10);
  endtask

  initial begin
    Reset = 1'b0; PB = '0; SW = '0;
    BUS_EN = 1'b0; BUS_RW = 1'b0; BUS_A = '0; BUS_WD = '0;
    tick(3);
    chk("rst_leds", {16'd0, LEDs}, 32'h0);
    chk("rst_rd", {24'd0, BUS_RD}, 32'h0);
    chk("rst_rv", {31'd0, BUS_RV}, 32'h0);
    chk("rst_irq", {31'd0, IRQ}, 32'h0);
    Reset = 1'b1;
    tick(2);
    bus_read(8'hF0, "rst_status", 8'h00);

    // Clean press on channel 0
    press(0, 4'hA);
    chk("p1_irq_masked", {31'd0, IRQ}, 32'h0);
    bus_read(8'hF0, "p1_status", 8'h01);
    bus_read(8'hF2, "p1_ipdr0", 8'h0A);
    tick(1);
    chk("p1_rv_pulse", {31'd0, BUS_RV}, 32'h0);
    chk("p1_rd_hold", {24'd0, BUS_RD}, 32'h0A);
    bus_read(8'hF0, "p1_status_clr", 8'h00);

    // Short glitch must be rejected
    PB[0] = 1'b1;
    tick(2);
    PB[0] = 1'b0;
    tick(10);
    bus_read(8'hF0, "glitch_status", 8'h00);

    // Overrun and W1C
    press(0, 4'h3);
    press(0, 4'h5);
    bus_read(8'hF0, "ovr_status", 8'h05);
    bus_write(8'hF0, 8'h04);
    bus_read(8'hF0, "ovr_w1c", 8'h01);
    bus_read(8'hF2, "ovr_ipdr0", 8'h03);
    bus_read(8'hF0, "ovr_after", 8'h00);

    // Interrupt on channel 1
    bus_write(8'hF1, 8'h02);
    bus_read(8'hF1, "ctrl_rb", 8'h02);
    press(1, 4'h7);
    chk("irq_set", {31'd0, IRQ}, 32'h1);
    bus_read(8'hF3, "irq_ipdr1", 8'h07);
    tick(2);
    chk("irq_clr", {31'd0, IRQ}, 32'h0);

    // LED registers and out-of-window accesses
    bus_write(8'hF4, 8'h5A);
    bus_write(8'hF5, 8'hC3);
    chk("leds", {16'd0, LEDs}, 32'hC35A);
    bus_write(8'hFF, 8'hFF);
    chk("leds_ff_ign", {16'd0, LEDs}, 32'hC35A);
    bus_read(8'hFF, "rd_ff", 8'h00);
    bus_read(8'hF5, "rd_opdr1", 8'hC3);
    bus_read(8'h10, "rd_below", 8'h00);

    // Reset mid-debounce discards the pending press
    PB[0] = 1'b1;
    tick(4);
    Reset = 1'b0;
    #2;
    chk("mid_rst_leds", {16'd0, LEDs}, 32'h0);
    PB[0] = 1'b0;
    tick(2);
    Reset = 1'b1;
    tick(12);
    bus_read(8'hF0, "mid_rst_status", 8'h00);
    chk("mid_rst_irq", {31'd0, IRQ}, 32'h0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
